// File: rtl/rot_lut_server_pkg.sv
// Shared constants, CORDIC tables and state encodings for the rotation LUT server.
// The arctangent table and gain reciprocal are generated for PHASE_SHIFT+GUARD = 15 and GUARD = 6.
package rot_lut_server_pkg;

    localparam int ROTATE_LUT_LEN_SHIFT   = 9;
    localparam int ROTATE_LUT_SCALE_SHIFT = 11;
    localparam int ATAN_LUT_SCALE_SHIFT   = 9;
    localparam int CORDIC_ITERS           = 16;
    localparam int CORDIC_GUARD           = 6;

    // round(2^(AMP_SHIFT+GUARD) / 1.646760)
    localparam int CORDIC_INV_GAIN = 79594;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_ITER  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OUT_ZERO  = 2'd0,
        OUT_IDENT = 2'd1,
        OUT_RAM   = 2'd2
    } out_sel_e;

    // round(atan(2^-i) * 2^15)
    function automatic int cordic_atan(input int i);
        int r;
        case (i)
            0:       r = 25736;
            1:       r = 15193;
            2:       r = 8027;
            3:       r = 4075;
            4:       r = 2045;
            5:       r = 1024;
            6:       r = 512;
            7:       r = 256;
            8:       r = 128;
            9:       r = 64;
            10:      r = 32;
            11:      r = 16;
            12:      r = 8;
            13:      r = 4;
            14:      r = 2;
            15:      r = 1;
            default: r = 0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rot_lut_ram.sv
// Simple dual-port LUT storage: one write port, one registered read port, no reset on contents.
// Read latency is one cycle; a same-cycle write to the read address returns the old word.
module rot_lut_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_dat_q;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat_q <= mem[rd_addr];
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/rot_lut_server.sv
// Rotation LUT responder: fills a {cos,sin} table with an iterative CORDIC, then serves 1-cycle reads.
// Optional ROT_LUT_CHECKSUM_EN adds lut_checksum, the modulo-2^32 sum of all words written by a fill.
module rot_lut_server
    import rot_lut_server_pkg::*;
#(
    parameter int ADDR_W      = ROTATE_LUT_LEN_SHIFT,
    parameter int PHASE_SHIFT = ATAN_LUT_SCALE_SHIFT,
    parameter int AMP_SHIFT   = ROTATE_LUT_SCALE_SHIFT,
    parameter int ITERS       = CORDIC_ITERS,
    parameter int GUARD       = CORDIC_GUARD
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              recompute,
    input  logic [ADDR_W-1:0] rot_addr,
    output logic [31:0]       rot_data,
`ifdef ROT_LUT_CHECKSUM_EN
    output logic              lut_ready,
    output logic [31:0]       lut_checksum
`else
    output logic              lut_ready
`endif
);

    localparam int XY_W = AMP_SHIFT + GUARD + 3;
    localparam int Z_W  = PHASE_SHIFT + GUARD + 2;
    localparam int IT_W = $clog2(ITERS);

    localparam logic signed [XY_W-1:0] X_SEED   = XY_W'(CORDIC_INV_GAIN);
    localparam logic signed [XY_W-1:0] AMP_ONE  = XY_W'(1 << AMP_SHIFT);
    localparam logic signed [XY_W-1:0] RND_HALF = XY_W'(1 << (GUARD - 1));
    localparam logic [IT_W-1:0]        IT_LAST  = IT_W'(ITERS - 1);
    localparam logic [ADDR_W-1:0]      ADDR_LAST = '1;
    localparam logic [31:0]            IDENT_WORD = {16'(1 << AMP_SHIFT), 16'h0000};

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        fill_addr_q, fill_addr_d;
    logic [IT_W-1:0]          iter_q, iter_d;
    logic signed [XY_W-1:0]   x_q, x_d;
    logic signed [XY_W-1:0]   y_q, y_d;
    logic signed [Z_W-1:0]    z_q, z_d;
    logic                     lut_ready_q, lut_ready_d;
    out_sel_e                 out_sel_q, out_sel_d;

    logic                     wr_en;
    logic [31:0]              wr_dat;
    logic [31:0]              ram_rd_dat;

    // Drop the guard bits with round-half-up, then clamp into [0, unit amplitude].
    function automatic logic [15:0] round_sat(input logic signed [XY_W-1:0] v);
        logic signed [XY_W-1:0] r;
        r = (v + RND_HALF) >>> GUARD;
        if (r < 0) begin
            r = '0;
        end else if (r > AMP_ONE) begin
            r = AMP_ONE;
        end
        return r[15:0];
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (recompute) begin
            state_d = ST_SEED;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_SEED;
                ST_SEED:  state_d = ST_ITER;
                ST_ITER:  state_d = (iter_q == IT_LAST) ? ST_WRITE : ST_ITER;
                ST_WRITE: state_d = (fill_addr_q == ADDR_LAST) ? ST_DONE : ST_SEED;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        fill_addr_d = fill_addr_q;
        iter_d      = iter_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        lut_ready_d = lut_ready_q;
        wr_en       = 1'b0;
        wr_dat      = {round_sat(x_q), round_sat(y_q)};
        if (recompute) begin
            fill_addr_d = '0;
            lut_ready_d = 1'b0;
        end else begin
            case (state_q)
                ST_SEED: begin
                    x_d    = X_SEED;
                    y_d    = '0;
                    z_d    = '0;
                    z_d[ADDR_W+GUARD-1:GUARD] = fill_addr_q;
                    iter_d = '0;
                end
                ST_ITER: begin
                    // Rotate toward z = 0; a negative residual angle turns the vector back.
                    if (z_q < 0) begin
                        x_d = x_q + (y_q >>> iter_q);
                        y_d = y_q - (x_q >>> iter_q);
                        z_d = z_q + Z_W'(cordic_atan(int'(iter_q)));
                    end else begin
                        x_d = x_q - (y_q >>> iter_q);
                        y_d = y_q + (x_q >>> iter_q);
                        z_d = z_q - Z_W'(cordic_atan(int'(iter_q)));
                    end
                    iter_d = iter_q + 1'b1;
                end
                ST_WRITE: begin
                    wr_en = 1'b1;
                    if (fill_addr_q != ADDR_LAST) begin
                        fill_addr_d = fill_addr_q + 1'b1;
                    end
                end
                ST_DONE: lut_ready_d = 1'b1;
                default: ;
            endcase
        end
        // Select follows the next ready value so identity is shown exactly while not ready.
        out_sel_d = lut_ready_d ? OUT_RAM : OUT_IDENT;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fill_addr_q <= '0;
            iter_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            lut_ready_q <= 1'b0;
            out_sel_q   <= OUT_ZERO;
        end else begin
            fill_addr_q <= fill_addr_d;
            iter_q      <= iter_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            lut_ready_q <= lut_ready_d;
            out_sel_q   <= out_sel_d;
        end
    end

    rot_lut_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (fill_addr_q),
        .wr_dat  (wr_dat),
        .rd_addr (rot_addr),
        .rd_dat  (ram_rd_dat)
    );

    always_comb begin
        case (out_sel_q)
            OUT_IDENT: rot_data = IDENT_WORD;
            OUT_RAM:   rot_data = ram_rd_dat;
            default:   rot_data = '0;
        endcase
    end

    assign lut_ready = lut_ready_q;

`ifdef ROT_LUT_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (!recompute) begin
            if (state_q == ST_SEED && fill_addr_q == '0) begin
                checksum_d = '0;
            end else if (wr_en) begin
                checksum_d = checksum_q + wr_dat;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign lut_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_rot_lut_server.sv
// Bench for rot_lut_server: fill timing, identity while not ready, table accuracy against real cos/sin,
// recompute and mid-fill reset behaviour, with randomized read traffic.
module tb_rot_lut_server;

    localparam int          NENT  = 512;
    localparam logic [31:0] IDENT = 32'h0800_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        recompute = 1'b0;
    logic [8:0]  rot_addr = 9'd5;
    logic [31:0] rot_data;
    logic        lut_ready;
`ifdef ROT_LUT_CHECKSUM_EN
    logic [31:0] lut_checksum;
    logic [31:0] csum_first;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_ready;
    int n_bad;
    logic [31:0] sweep_sum;

    rot_lut_server dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .recompute    (recompute),
        .rot_addr     (rot_addr),
        .rot_data     (rot_data),
`ifdef ROT_LUT_CHECKSUM_EN
        .lut_ready    (lut_ready),
        .lut_checksum (lut_checksum)
`else
        .lut_ready    (lut_ready)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Ideal table entry: round(2048 * cos|sin(k/512)), clamped to [0, 2048].
    function automatic int ref_val(input int k, input bit want_sin);
        real a;
        real v;
        int  r;
        a = real'(k) / 512.0;
        v = want_sin ? 2048.0 * $sin(a) : 2048.0 * $cos(a);
        r = $rtoi(v + 0.5);
        if (r < 0) r = 0;
        if (r > 2048) r = 2048;
        return r;
    endfunction

    task automatic check_val(input string tag, input int got, input int exp, input int tol);
        checks++;
        if (got - exp > tol || exp - got > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tolerance %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic read_check(input int k, input string tag);
        logic signed [15:0] c16;
        logic signed [15:0] s16;
        rot_addr = 9'(k);
        @(posedge clock);
        #1;
        c16 = rot_data[31:16];
        s16 = rot_data[15:0];
        check_val($sformatf("%s_cos_%0d", tag, k), int'(c16), ref_val(k, 1'b0), 1);
        check_val($sformatf("%s_sin_%0d", tag, k), int'(s16), ref_val(k, 1'b1), 1);
        sweep_sum = sweep_sum + rot_data;
    endtask

    // Count clock edges until lut_ready, noting any non-identity output seen meanwhile.
    task automatic wait_ready(output int n, output int bad);
        n   = -1;
        bad = 0;
        for (int i = 1; i <= 10000; i++) begin
            @(posedge clock);
            #1;
            if (lut_ready) begin
                n = i;
                break;
            end
            if (rot_data !== IDENT) bad++;
        end
    endtask

    task automatic sweep(input string tag);
        sweep_sum = '0;
        for (int k = 0; k < NENT; k++) begin
            read_check(k, tag);
        end
    endtask

    task automatic random_reads(input int cnt, input string tag);
        for (int i = 0; i < cnt; i++) begin
            read_check(int'($urandom_range(NENT - 1)), tag);
        end
    endtask

    initial begin
        logic signed [15:0] c16;
        logic signed [15:0] s16;

        repeat (3) @(posedge clock);
        #1;
        check_val("reset_ready", int'(lut_ready), 0, 0);
        check_val("reset_data", int'(rot_data), 0, 0);

        @(negedge clock);
        reset_n = 1'b1;
        wait_ready(n_ready, n_bad);
        check_val("first_fill_cycles", n_ready, 9218, 0);
        check_val("first_fill_ident", n_bad, 0, 0);

        rot_addr = 9'd0;
        @(posedge clock);
        #1;
        check_val("addr0_exact", int'(rot_data), int'(IDENT), 0);

        rot_addr = 9'd256;
        @(posedge clock);
        #1;
        c16 = rot_data[31:16];
        s16 = rot_data[15:0];
        check_val("addr256_cos", int'(c16), 1797, 1);
        check_val("addr256_sin", int'(s16), 982, 1);

        rot_addr = 9'd402;
        @(posedge clock);
        #1;
        c16 = rot_data[31:16];
        s16 = rot_data[15:0];
        check_val("addr402_cos", int'(c16), 1448, 1);
        check_val("addr402_sin", int'(s16), 1448, 1);

        sweep("sweep1");
`ifdef ROT_LUT_CHECKSUM_EN
        csum_first = lut_checksum;
        check_val("checksum_vs_table", int'(lut_checksum), int'(sweep_sum), 0);
`endif
        random_reads(200, "rand1");

        while (cyc < 20000) @(posedge clock);
        #1;
        recompute = 1'b1;
        rot_addr  = 9'd100;
        @(posedge clock);
        #1;
        recompute = 1'b0;
        check_val("recompute_ready_low", int'(lut_ready), 0, 0);
        check_val("recompute_ident", int'(rot_data), int'(IDENT), 0);
        wait_ready(n_ready, n_bad);
        check_val("refill_cycles", n_ready, 9217, 0);
        check_val("refill_ident", n_bad, 0, 0);
        sweep("sweep2");
`ifdef ROT_LUT_CHECKSUM_EN
        check_val("checksum_stable", int'(lut_checksum), int'(csum_first), 0);
`endif

        recompute = 1'b1;
        @(posedge clock);
        #1;
        recompute = 1'b0;
        repeat (4000) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_val("midreset_ready", int'(lut_ready), 0, 0);
        check_val("midreset_data", int'(rot_data), 0, 0);
        repeat (2) @(posedge clock);
        #1;
        check_val("midreset_data_held", int'(rot_data), 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        wait_ready(n_ready, n_bad);
        check_val("postreset_fill_cycles", n_ready, 9218, 0);
        check_val("postreset_ident", n_bad, 0, 0);
        random_reads(100, "rand2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
